armv4_ram_slave: RTL and testbench



---
 rtl/armv4_ram_slave.sv | 178 +++++++++++++++++
 tb/tb_armv4_ram_slave.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/armv4_ram_slave.sv
// armv4_ram_slave: responder for the armv4core RAM bus with byte-lane data RAM and an
// MMIO countdown timer whose pending flag drives the core interrupt inputs.
module armv4_ram_slave #(
  parameter int unsigned MEM_BYTES = 65536,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ram_en,
  input  logic        i_ram_wr,
  input  logic [1:0]  i_ram_size,
  input  logic [31:0] i_ram_addr,
  input  logic [31:0] i_ram_wdata,
  output logic [31:0] o_ram_rdata,
  output logic        o_irq,
  output logic [31:0] o_irq_r0
);

  // Access size codes shared with the core (def.v): byte, halfword, anything else = word.
  localparam logic [1:0]  MemB     = 2'd0;
  localparam logic [1:0]  MemH     = 2'd1;
  localparam int unsigned AddrW    = $clog2(MEM_BYTES);
  localparam int unsigned Depth    = MEM_BYTES / 4;
  localparam logic [31:0] MemLimit = 32'(MEM_BYTES);

  logic [7:0] mem [4][Depth];

  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic [31:0] irqval_q, irqval_d;
  logic [2:0]  status_q, status_d;
  logic        irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d;

  logic [AddrW-3:0] word_idx;
  logic [1:0]       lane;
  logic [31:0]      mmio_off;
  logic             ram_hit, mmio_hit, is_b, is_h, misalign;
  logic [7:0]       rd_lane [4];
  logic [7:0]       lane_wdata [4];
  logic [3:0]       ram_we_mask, lane_we;
  logic [31:0]      ram_rd, mmio_rd;
  logic [2:0]       set_flags;

  assign word_idx = i_ram_addr[AddrW-1:2];
  assign lane     = i_ram_addr[1:0];
  assign mmio_off = i_ram_addr - MMIO_BASE;
  assign ram_hit  = i_ram_addr < MemLimit;
  assign mmio_hit = (i_ram_addr >= MMIO_BASE) && (mmio_off < 32'd32);
  assign is_b     = i_ram_size == MemB;
  assign is_h     = i_ram_size == MemH;

  // MMIO is word-only, so any sub-word offset there counts as misaligned.
  always_comb begin
    if (mmio_hit)  misalign = lane != 2'b00;
    else if (is_b) misalign = 1'b0;
    else if (is_h) misalign = lane[0];
    else           misalign = lane != 2'b00;
  end

  always_comb begin
    for (int l = 0; l < 4; l++) begin
      rd_lane[l] = mem[l][word_idx];
      if (is_b)      lane_wdata[l] = i_ram_wdata[7:0];
      else if (is_h) lane_wdata[l] = l[0] ? i_ram_wdata[15:8] : i_ram_wdata[7:0];
      else           lane_wdata[l] = i_ram_wdata[8*l +: 8];
    end
  end

  always_comb begin
    if (is_b) begin
      ram_we_mask = 4'b0001 << lane;
      ram_rd      = {24'b0, rd_lane[lane]};
    end else if (is_h) begin
      ram_we_mask = lane[1] ? 4'b1100 : 4'b0011;
      ram_rd      = lane[1] ? {16'b0, rd_lane[3], rd_lane[2]} : {16'b0, rd_lane[1], rd_lane[0]};
    end else begin
      ram_we_mask = 4'b1111;
      ram_rd      = {rd_lane[3], rd_lane[2], rd_lane[1], rd_lane[0]};
    end
  end

  always_comb begin
    case (mmio_off[4:2])
      3'd0:    mmio_rd = {29'b0, ctrl_q};
      3'd1:    mmio_rd = load_q;
      3'd2:    mmio_rd = count_q;
      3'd3:    mmio_rd = irqval_q;
      3'd4:    mmio_rd = {29'b0, status_q};
      default: mmio_rd = 32'b0;
    endcase
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    load_d    = load_q;
    count_d   = count_q;
    irqval_d  = irqval_q;
    status_d  = status_q;
    rdata_d   = rdata_q;
    lane_we   = 4'b0000;
    set_flags = 3'b000;

    // Timer: expiry sets PEND, then reloads or disarms.
    if (ctrl_q[0]) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else begin
        set_flags[0] = 1'b1;
        if (ctrl_q[1]) count_d = load_q;
        else           ctrl_d[0] = 1'b0;
      end
    end

    if (i_ram_en && !rst) begin
      set_flags[1] = misalign;
      if (ram_hit) begin
        if (i_ram_wr) lane_we = ram_we_mask;
        else          rdata_d = ram_rd;
      end else if (mmio_hit) begin
        if (i_ram_wr) begin
          case (mmio_off[4:2])
            3'd0: begin
              ctrl_d = i_ram_wdata[2:0];
              if (!ctrl_q[0] && i_ram_wdata[0]) count_d = load_q;
            end
            3'd1:    load_d   = i_ram_wdata;
            3'd3:    irqval_d = i_ram_wdata;
            3'd4:    status_d = status_q & ~i_ram_wdata[2:0];
            default: ;
          endcase
        end else begin
          rdata_d = mmio_rd;
        end
      end else begin
        set_flags[2] = 1'b1;
        if (!i_ram_wr) rdata_d = 32'b0;
      end
    end

    // New events win over a simultaneous write-1-to-clear.
    status_d = status_d | set_flags;
    irq_d    = status_q[0] & ctrl_q[2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= '0;
      load_q   <= '0;
      count_q  <= '0;
      irqval_q <= '0;
      status_q <= '0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      load_q   <= load_d;
      count_q  <= count_d;
      irqval_q <= irqval_d;
      status_q <= status_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (lane_we[l]) mem[l][word_idx] <= lane_wdata[l];
    end
  end

  assign o_ram_rdata = rdata_q;
  assign o_irq       = irq_q;
  assign o_irq_r0    = irqval_q;

endmodule

// File: tb/tb_armv4_ram_slave.sv
// Directed self-checking bench for armv4_ram_slave: RAM lanes, status flags, timer and reset.
module tb_armv4_ram_slave;

  localparam logic [1:0]  SzB    = 2'd0;
  localparam logic [1:0]  SzH    = 2'd1;
  localparam logic [1:0]  SzW    = 2'd2;
  localparam logic [31:0] ACtrl  = 32'hFFFF_0000;
  localparam logic [31:0] ALoad  = 32'hFFFF_0004;
  localparam logic [31:0] ACount = 32'hFFFF_0008;
  localparam logic [31:0] AIrqv  = 32'hFFFF_000C;
  localparam logic [31:0] AStat  = 32'hFFFF_0010;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        irq;
  logic [31:0] irq_r0;

  int checks = 0;
  int errors = 0;

  armv4_ram_slave dut (
    .clk         (clk),
    .rst         (rst),
    .i_ram_en    (en),
    .i_ram_wr    (wr),
    .i_ram_size  (size),
    .i_ram_addr  (addr),
    .i_ram_wdata (wdata),
    .o_ram_rdata (rdata),
    .o_irq       (irq),
    .o_irq_r0    (irq_r0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_acc(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    en = 1'b1; wr = 1'b1; size = sz; addr = a; wdata = d;
    tick();
    en = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] exp);
    en = 1'b1; wr = 1'b0; size = sz; addr = a; wdata = 32'h0;
    tick();
    en = 1'b0;
    chk(tag, rdata, exp);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wr = 1'b0; size = SzW; addr = 32'h0; wdata = 32'h0;
    repeat (2) tick();
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);
    chk("reset_irq_r0", irq_r0, 32'h0);
    rst = 1'b0;

    // Lane extraction
    wr_acc(SzW, 32'h100, 32'h1234_5678);
    rd_chk("byte_101", SzB, 32'h101, 32'h0000_0056);
    rd_chk("half_102", SzH, 32'h102, 32'h0000_1234);
    rd_chk("word_100", SzW, 32'h100, 32'h1234_5678);
    wr_acc(SzB, 32'h103, 32'h0000_00AB);
    rd_chk("word_after_byte", SzW, 32'h100, 32'hAB34_5678);
    wr_acc(SzW, 32'h200, 32'hCAFE_F00D);
    rd_chk("write_then_read", SzW, 32'h200, 32'hCAFE_F00D);
    wr_acc(SzH, 32'h206, 32'h0000_BEEF);
    rd_chk("half_write", SzW, 32'h204, 32'hBEEF_0000);
    rd_chk("read_hold_status", SzW, AStat, 32'h0);

    // Error flags
    rd_chk("misaligned_word", SzW, 32'h102, 32'hAB34_5678);
    rd_chk("status_misalign", SzW, AStat, 32'h2);
    rd_chk("unmapped_read", SzW, 32'h0001_0000, 32'h0);
    rd_chk("status_buserr", SzW, AStat, 32'h6);
    tick();
    chk("rdata_holds_idle", rdata, 32'h6);
    wr_acc(SzW, AStat, 32'h6);
    rd_chk("status_cleared", SzW, AStat, 32'h0);

    // Periodic timer: CTRL write edge E0, PEND at E10, o_irq at E11
    wr_acc(SzW, AIrqv, 32'h0123_4567);
    chk("irq_r0_value", irq_r0, 32'h0123_4567);
    wr_acc(SzW, ALoad, 32'd9);
    wr_acc(SzW, ACtrl, 32'h7);
    repeat (9) tick();
    chk("irq_low_e9", {31'b0, irq}, 32'h0);
    tick();
    chk("irq_low_e10", {31'b0, irq}, 32'h0);
    tick();
    chk("irq_rise_e11", {31'b0, irq}, 32'h1);
    // W1C at E12; o_irq drops at E13; next PEND at E20, o_irq at E21
    wr_acc(SzW, AStat, 32'h1);
    chk("irq_still_e12", {31'b0, irq}, 32'h1);
    tick();
    chk("irq_drop_e13", {31'b0, irq}, 32'h0);
    repeat (7) tick();
    chk("irq_low_e20", {31'b0, irq}, 32'h0);
    tick();
    chk("irq_rearm_e21", {31'b0, irq}, 32'h1);
    wr_acc(SzW, ACtrl, 32'h0);
    wr_acc(SzW, AStat, 32'h1);

    // One-shot: CTRL edge B0, COUNT 3->0 by B3, PEND at B4, o_irq at B5
    wr_acc(SzW, ALoad, 32'd3);
    wr_acc(SzW, ACtrl, 32'h5);
    repeat (4) tick();
    chk("oneshot_irq_b4", {31'b0, irq}, 32'h0);
    tick();
    chk("oneshot_irq_b5", {31'b0, irq}, 32'h1);
    rd_chk("oneshot_ctrl", SzW, ACtrl, 32'h4);
    rd_chk("oneshot_count", SzW, ACount, 32'h0);
    rd_chk("oneshot_status", SzW, AStat, 32'h1);
    wr_acc(SzW, AStat, 32'h1);
    repeat (3) tick();
    rd_chk("oneshot_single", SzW, AStat, 32'h0);

    // Reset while running with PEND set
    wr_acc(SzW, ALoad, 32'd2);
    wr_acc(SzW, ACtrl, 32'h7);
    repeat (5) tick();
    chk("run_irq_before_rst", {31'b0, irq}, 32'h1);
    rd_chk("rdata_before_rst", SzW, 32'h200, 32'hCAFE_F00D);
    rst = 1'b1; en = 1'b1; wr = 1'b1; size = SzW; addr = 32'h100; wdata = 32'h1111_1111;
    tick();
    rst = 1'b0; en = 1'b0; wr = 1'b0;
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_irq_r0", irq_r0, 32'h0);
    rd_chk("rst_ctrl", SzW, ACtrl, 32'h0);
    rd_chk("rst_count", SzW, ACount, 32'h0);
    rd_chk("rst_status", SzW, AStat, 32'h0);
    rd_chk("ram_survives_rst", SzW, 32'h100, 32'hAB34_5678);
    rd_chk("ram2_survives_rst", SzW, 32'h200, 32'hCAFE_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
